// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified instruction/data memory port arbiter.
// Owner encoding of the outstanding read and default counter sizing live here.
package mem_port_arbiter_pkg;
  localparam int FULLW          = 32;
  localparam int STARVE_MAX_DEF = 3;
  localparam int STARVE_W       = 4;
  localparam int CONFLICT_W     = 8;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;
endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Used for fetch starvation tracking and the debug conflict counter.
module mem_port_arbiter_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and data access.
// Data has fixed priority; fetch wins once it has been starved STARVE_MAX cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = FULLW,
  parameter int DW         = FULLW,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_q,
  output logic [7:0]    conflict_cnt
);
  logic [STARVE_W-1:0] starve_q;
  logic [AW-1:0]       mem_ad_q;
  logic                rd_pend_q;
  owner_e              rd_owner_q;
  logic                fetch_wins;
  logic                d_read_gnt;

  assign fetch_wins = i_req & (~d_req | (starve_q >= STARVE_W'(STARVE_MAX)));

  // Grants are gated by reset so requests held during reset are never accepted.
  assign i_gnt      = nreset & fetch_wins;
  assign d_gnt      = nreset & d_req & ~fetch_wins;
  assign d_read_gnt = d_gnt & ~d_we;

  assign mem_ad = i_gnt ? i_addr : (d_gnt ? d_addr : mem_ad_q);
  assign mem_we = d_gnt & d_we;
  assign mem_d  = d_wdata;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem_ad_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWNER_I;
    end else begin
      mem_ad_q  <= mem_ad;
      rd_pend_q <= i_gnt | d_read_gnt;
      if (i_gnt) begin
        rd_owner_q <= OWNER_I;
      end else if (d_read_gnt) begin
        rd_owner_q <= OWNER_D;
      end
    end
  end

  assign i_rvalid = rd_pend_q & (rd_owner_q == OWNER_I);
  assign d_rvalid = rd_pend_q & (rd_owner_q == OWNER_D);
  assign i_rdata  = mem_q;
  assign d_rdata  = mem_q;

  mem_port_arbiter_sat_counter #(.W(STARVE_W)) u_starve (
    .clk    (clk),
    .nreset (nreset),
    .inc    (i_req & ~i_gnt),
    .clr    (~i_req | i_gnt),
    .cnt    (starve_q)
  );

  mem_port_arbiter_sat_counter #(.W(CONFLICT_W)) u_conflict (
    .clk    (clk),
    .nreset (nreset),
    .inc    (i_req & d_req),
    .clr    (1'b0),
    .cnt    (conflict_cnt)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a write-first RAM model.
// Expected grants and read responses come from a behavioural model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int SM = 3;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_ad, mem_d, mem_q;
  logic        mem_we;
  logic [7:0]  conflict_cnt;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .nreset(nreset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ad(mem_ad), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Write-first synchronous RAM, 64 words
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (mem_we) ram[mem_ad[5:0]] <= mem_d;
    mem_q <= mem_we ? mem_d : ram[mem_ad[5:0]];
  end

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } rsp_t;
  rsp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [64];
  int          fetch_wait = 0;
  int          ref_conf = 0;
  logic [31:0] last_ad = '0;
  logic        gi = 1'b0;
  logic        gd = 1'b0;
  logic        dut_ig = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare this cycle's grant-side outputs against the model, then advance the model.
  task automatic eval();
    logic        ei, ed;
    logic [31:0] ead;
    #1;
    ei  = i_req & (!d_req || fetch_wait >= SM);
    ed  = d_req & !ei;
    ead = ei ? i_addr : (ed ? d_addr : last_ad);
    dut_ig = i_gnt;
    chk("i_gnt", 32'(i_gnt), 32'(ei));
    chk("d_gnt", 32'(d_gnt), 32'(ed));
    chk("mem_ad", mem_ad, ead);
    chk("mem_we", 32'(mem_we), 32'(ed & d_we));
    if (ed && d_we) chk("mem_d", mem_d, d_wdata);
    chk("conflict_cnt", 32'(conflict_cnt), 32'(ref_conf));
    if (ei) sb.push_back('{1'b0, ref_mem[i_addr[5:0]]});
    if (ed && !d_we) sb.push_back('{1'b1, ref_mem[d_addr[5:0]]});
    if (ed && d_we) ref_mem[d_addr[5:0]] = d_wdata;
    last_ad    = ead;
    fetch_wait = (i_req && !ei) ? ((fetch_wait < 15) ? fetch_wait + 1 : 15) : 0;
    if (i_req && d_req && ref_conf < 255) ref_conf++;
    gi = ei;
    gd = ed;
  endtask

  task automatic step();
    eval();
    @(negedge clk);
  endtask

  // Response monitor: exactly one rvalid per granted read, one cycle later, with owner's data.
  initial begin
    rsp_t        e;
    logic [1:0]  exp_v;
    forever begin
      @(posedge clk);
      #2;
      exp_v = 2'b00;
      if (sb.size() > 0) exp_v = sb[0].owner ? 2'b01 : 2'b10;
      chk("rvalid_id", {30'd0, i_rvalid, d_rvalid}, {30'd0, exp_v});
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.owner) chk("d_rdata", d_rdata, e.data);
        else         chk("i_rdata", i_rdata, e.data);
        $display("rsp owner=%s data=%h", e.owner ? "D" : "I", e.owner ? d_rdata : i_rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_fg;
    // Reset with both requests pending: nothing may be granted
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_ad", mem_ad, 32'd0);
    chk("rst_conflict", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    // Re-arbitration after reset: data write wins, then fetch reads the new data
    step();
    d_req = 1'b0;
    step();
    i_req = 1'b0;

    // Prefill RAM through the data port
    for (int k = 0; k < 64; k++) begin
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'(k); d_wdata = $urandom;
      step();
    end
    d_req = 1'b0;
    step();

    // Lone fetch
    i_req = 1'b1; i_addr = 32'h10;
    step();
    i_req = 1'b0;
    step();

    // Conflict: both held reading
    i_req = 1'b1; i_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    repeat (8) step();
    i_req = 1'b0; d_req = 1'b0;
    step();

    // Write then read same address on consecutive cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    step();
    d_we = 1'b0;
    step();
    d_req = 1'b0;
    step();

    // Randomised traffic; requesters hold their payload until granted
    gi = 1'b0; gd = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!i_req || gi) begin
        i_req  = ($urandom_range(0, 99) < 60);
        i_addr = 32'($urandom_range(0, 63));
      end
      if (!d_req || gd) begin
        d_req   = ($urandom_range(0, 99) < 60);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
    step();

    // Reset while a fetch read is outstanding
    i_req = 1'b1; i_addr = 32'h10;
    eval();
    #2;
    nreset = 1'b0;
    #1;
    chk("mid_i_gnt", 32'(i_gnt), 32'd0);
    chk("mid_d_gnt", 32'(d_gnt), 32'd0);
    chk("mid_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("mid_mem_we", 32'(mem_we), 32'd0);
    chk("mid_mem_ad", mem_ad, 32'd0);
    chk("mid_conflict", 32'(conflict_cnt), 32'd0);
    sb.delete();
    fetch_wait = 0; ref_conf = 0; last_ad = '0; gi = 1'b0; gd = 1'b0;
    repeat (2) @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    nreset = 1'b1;
    repeat (3) step();

    // Saturation: both held for 300 cycles
    i_req = 1'b1; i_addr = 32'h3;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5;
    n_fg = 0;
    for (int c = 0; c < 300; c++) begin
      eval();
      if (dut_ig) n_fg++;
      @(negedge clk);
    end
    #1;
    chk("conflict_sat", 32'(conflict_cnt), 32'd255);
    chk("fetch_grants", 32'(n_fg), 32'd75);
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
